// File: rtl/upower_pkg.sv
// Shared definitions for the uPower front end: instruction width, fetch FSM
// encoding, PC step and a saturating counter helper.
package upower_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h6000_0000;
    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // Sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, word} pairs between the fetch FSM and the
// decoder; the head entry is presented directly and zeroed while empty.
module fetch_buffer
    import upower_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_word,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_word,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int ENT_W = ADDR_W + INSTR_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;
    logic [ENT_W-1:0] head_entry;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A full buffer may still accept a word in the same cycle its head leaves.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_reg] <= {push_pc, push_word};
                wr_ptr_reg      <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_entry = mem[rd_ptr_reg];
    assign head_pc    = empty ? '0 : head_entry[ENT_W-1:INSTR_W];
    assign head_word  = empty ? '0 : head_entry[INSTR_W-1:0];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, one-outstanding memory request FSM, redirect/flush handling.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instruction_fetch
    import upower_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_word,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] FETCH = ST_FETCH;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] DRAIN = ST_DRAIN;

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] req_pc_reg, req_pc_next;

    logic              req_fire;
    logic              inst_fire;
    logic [ADDR_W-1:0] redirect_target;
    logic              buf_push;
    logic              buf_full;
    logic              buf_empty;
    logic [CNT_W-1:0]  buf_count;

    assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign imem_req_valid  = (state_reg == FETCH) && (buf_count < CNT_W'(BUF_DEPTH));
    assign imem_req_addr   = {pc_reg[ADDR_W-1:2], 2'b00};
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign inst_valid      = !buf_empty;
    assign inst_fire       = inst_valid && inst_ready;
    // A response that coincides with a redirect belongs to the old path.
    assign buf_push        = (state_reg == WAIT) && imem_rsp_valid && !redirect_valid && !buf_full;

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        req_pc_next = req_pc_reg;
        case (state_reg)
            IDLE:  state_next = FETCH;
            FETCH: begin
                if (req_fire) begin
                    req_pc_next = pc_reg;
                    pc_next     = pc_reg + ADDR_W'(PC_INC);
                    state_next  = WAIT;
                end
            end
            WAIT:    if (imem_rsp_valid) state_next = FETCH;
            DRAIN:   if (imem_rsp_valid) state_next = FETCH;
            default: state_next = IDLE;
        endcase
        // Redirect wins; drain only if a stale response is still to come.
        if (redirect_valid) begin
            pc_next = redirect_target;
            if (((state_reg == WAIT) && !imem_rsp_valid) ||
                ((state_reg == FETCH) && req_fire) ||
                ((state_reg == DRAIN) && !imem_rsp_valid)) begin
                state_next = DRAIN;
            end else begin
                state_next = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            req_pc_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            req_pc_reg <= req_pc_next;
        end
    end

    fetch_buffer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .pop       (inst_fire),
        .flush     (redirect_valid),
        .push_pc   (req_pc_reg),
        .push_word (imem_rsp_data),
        .head_pc   (inst_pc),
        .head_word (inst_word),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_flushed_reg;
    logic        rsp_dropped;
    logic [31:0] flush_amount;

    // DRAIN already accounted for its stale response when it was entered.
    assign rsp_dropped  = redirect_valid &&
                          ((state_reg == WAIT) || ((state_reg == FETCH) && req_fire));
    assign flush_amount = redirect_valid
                        ? (32'(buf_count) - 32'(inst_fire) + 32'(rsp_dropped))
                        : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_reg <= '0;
            perf_flushed_reg <= '0;
        end else begin
            perf_fetched_reg <= sat_add32(perf_fetched_reg, 32'(inst_fire));
            perf_flushed_reg <= sat_add32(perf_flushed_reg, flush_amount);
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_flushed = perf_flushed_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small one-outstanding memory model;
// the counter scenario is included when FETCH_PERF_CNT_EN is defined.
module tb_instruction_fetch;

    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b1;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready = 1'b1;
    logic [31:0]       inst_word;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_flushed;
`endif

    int errors = 0;
    int checks = 0;
    int mem_lat = 1;

    instruction_fetch #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (64'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_word      (inst_word),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] addr);
        return 32'h7C22_1A14 ^ addr[31:0];
    endfunction

    // Memory: one request at a time, response mem_lat cycles after acceptance.
    logic              pend = 1'b0;
    int                pend_cnt = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    int                accept_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            pend           <= 1'b0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= word_of(pend_addr);
                    pend           <= 1'b0;
                end else begin
                    pend_cnt <= pend_cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                accept_cnt <= accept_cnt + 1;
                if (mem_lat <= 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= word_of(imem_req_addr);
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= imem_req_addr;
                    pend_cnt  <= mem_lat - 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %s ok value=%0h", tag, obs);
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_inst(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (inst_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit seen;
        int a0;

        // Reset state and first fetch latency
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_lat        = 1;
        do_reset();
        check("reset_req_valid", 64'(imem_req_valid), 64'd0);
        check("reset_inst", {31'd0, inst_valid, inst_word}, 64'd0);
        check("reset_inst_pc", inst_pc, 64'd0);
        step();
        check("c1_req", {imem_req_valid, imem_req_addr[31:0]}, {1'b1, 32'h0});
        check("c1_inst_valid", 64'(inst_valid), 64'd0);
        step();
        check("c2_inst_valid", 64'(inst_valid), 64'd0);
        step();
        check("c3_inst_valid", 64'(inst_valid), 64'd1);
        check("c3_inst_word", 64'(inst_word), 64'h7C22_1A14);
        check("c3_inst_pc", inst_pc, 64'h0);
        check("c3_next_req", {imem_req_valid, imem_req_addr[31:0]}, {1'b1, 32'h4});

        // Decoder stalled: buffer fills, requests stop, head is stable
        inst_ready = 1'b0;
        do_reset();
        repeat (3) step();
        check("stall_first", {inst_valid, inst_pc[31:0]}, {1'b1, 32'h0});
        step();
        step();
        check("stall_full_no_req", 64'(imem_req_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("stall_hold", {inst_valid, imem_req_valid, inst_word, inst_pc[29:0]},
                  {1'b1, 1'b0, 32'h7C22_1A14, 30'h0});
        end
        inst_ready = 1'b1;
        step();
        check("drain_second", {inst_valid, inst_word, inst_pc[30:0]},
              {1'b1, word_of(64'h4), 31'h4});
        step();
        check("drain_empty", 64'(inst_valid), 64'd0);
        step();
        check("drain_third_pc", inst_pc, 64'h8);

        // Redirect while WAIT, response still pending: stale word dropped
        mem_lat = 3;
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        step();
        redirect_valid = 1'b0;
        check("rd_wait_flush", {inst_valid, imem_req_valid}, 2'b00);
        step();
        check("rd_wait_drain_no_req", 64'(imem_req_valid), 64'd0);
        step();
        check("rd_wait_new_req", {imem_req_valid, imem_req_addr[31:0]}, {1'b1, 32'h100});
        wait_inst(20, seen);
        check("rd_wait_seen", 64'(seen), 64'd1);
        check("rd_wait_pc", inst_pc, 64'h100);
        check("rd_wait_word", 64'(inst_word), 64'(word_of(64'h100)));

        // Redirect together with the response: no drain
        mem_lat = 1;
        do_reset();
        step();
        step();
        check("rd_rsp_rsp_present", 64'(imem_rsp_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        step();
        redirect_valid = 1'b0;
        check("rd_rsp_req_now", {inst_valid, imem_req_valid, imem_req_addr[31:0]},
              {1'b0, 1'b1, 32'h200});
        wait_inst(20, seen);
        check("rd_rsp_seen", 64'(seen), 64'd1);
        check("rd_rsp_pc", inst_pc, 64'h200);
        check("rd_rsp_word", 64'(inst_word), 64'(word_of(64'h200)));

        // Memory not ready for 5 cycles: address held, single acceptance
        imem_req_ready = 1'b0;
        do_reset();
        a0 = accept_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check("nrdy_hold", {imem_req_valid, imem_req_addr[31:0]}, {1'b1, 32'h0});
        end
        imem_req_ready = 1'b1;
        step();
        check("nrdy_accept_once", 64'(accept_cnt - a0), 64'd1);
        check("nrdy_wait_no_req", 64'(imem_req_valid), 64'd0);
        step();
        check("nrdy_no_extra", 64'(accept_cnt - a0), 64'd1);
        check("nrdy_next_addr", imem_req_addr, 64'h4);

`ifdef FETCH_PERF_CNT_EN
        // Counters: flush a full buffer, then an in-flight request
        inst_ready = 1'b0;
        mem_lat    = 1;
        do_reset();
        check("perf_reset", {perf_fetched, perf_flushed}, 64'd0);
        repeat (5) step();
        check("perf_full", 64'(imem_req_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h300;
        step();
        redirect_valid = 1'b0;
        check("perf_flushed_buf", 64'(perf_flushed), 64'd2);
        check("perf_req_target", {imem_req_valid, imem_req_addr[31:0]}, {1'b1, 32'h300});
        mem_lat = 3;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h400;
        step();
        redirect_valid = 1'b0;
        mem_lat        = 1;
        check("perf_flushed_total", 64'(perf_flushed), 64'd3);
        check("perf_fetched_none", 64'(perf_fetched), 64'd0);
        inst_ready = 1'b1;
        wait_inst(20, seen);
        check("perf_seen", {seen, inst_pc[31:0]}, {1'b1, 32'h400});
        step();
        check("perf_fetched_one", 64'(perf_fetched), 64'd1);
        check("perf_flushed_keep", 64'(perf_flushed), 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
